// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that drive Decode stalls
// on RAW collisions and counter saturation, with WB retire and E-stage cancel.
module reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS_WB = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reg_WE,
  input  logic [1:0]          reg_RD,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic [ADDR_W-1:0]   rs3,
  input  logic                reg_WE_WB,
  input  logic [ADDR_W-1:0]   rs3_WB,
  input  logic                cancel,
  input  logic [ADDR_W-1:0]   rs3_cancel,
  output logic                stall_F,
  output logic                stall_D,
  output logic                stall_E,
  output logic                stall_M,
  output logic                stall_WB,
  output logic                flush_F,
  output logic                flush_D,
  output logic                flush_E,
  output logic                flush_M,
  output logic                flush_WB,
  output logic [NUM_REGS-1:0] busy,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0] pend_d [NUM_REGS];
  logic             uf_q;
  logic             uf_d;
  logic             hit1_s;
  logic             hit2_s;
  logic             collision_s;
  logic             saturate_s;
  logic             stall_raw_s;
  logic             issue_s;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  // A reg is a hazard unless this cycle's WB retire drains its last pending write.
  function automatic logic hit_f(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] p,
                                 input logic we_wb, input logic [ADDR_W-1:0] a_wb);
    logic drain;
    drain = (BYPASS_WB != 0) && we_wb && (a_wb == a) && (p == CNT_ONE);
    return (p != {CNT_W{1'b0}}) && !is_zero(a) && !drain;
  endfunction

  // Hazard detection is purely combinational on current state and Decode inputs.
  always_comb begin
    hit1_s      = hit_f(rs1, pend_q[rs1], reg_WE_WB, rs3_WB);
    hit2_s      = hit_f(rs2, pend_q[rs2], reg_WE_WB, rs3_WB);
    collision_s = (reg_RD[0] && hit1_s) || (reg_RD[1] && hit2_s);
    saturate_s  = reg_WE && (pend_q[rs3] == CNT_MAX) && !is_zero(rs3);
    stall_raw_s = collision_s || saturate_s;
    issue_s     = reg_WE && !stall_raw_s && !is_zero(rs3);
  end

  assign stall_F  = stall_raw_s && !reset;
  assign stall_D  = stall_raw_s && !reset;
  assign flush_E  = stall_raw_s && !reset;
  assign stall_E  = 1'b0;
  assign stall_M  = 1'b0;
  assign stall_WB = 1'b0;
  assign flush_F  = 1'b0;
  assign flush_D  = 1'b0;
  assign flush_M  = 1'b0;
  assign flush_WB = 1'b0;

  // Counter update: +issue -retire -cancel, clamped at zero with a sticky error.
  always_comb begin
    logic [CNT_W+1:0] nxt;
    uf_d = uf_q;
    nxt  = {(CNT_W+2){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      nxt = {2'b00, pend_q[i]}
          + {{(CNT_W+1){1'b0}}, (issue_s && (rs3 == ADDR_W'(i)))}
          - {{(CNT_W+1){1'b0}}, (reg_WE_WB && (rs3_WB == ADDR_W'(i)))}
          - {{(CNT_W+1){1'b0}}, (cancel && (rs3_cancel == ADDR_W'(i)))};
      if (is_zero(ADDR_W'(i))) begin
        pend_d[i] = {CNT_W{1'b0}};
      end else if (nxt[CNT_W+1]) begin
        pend_d[i] = {CNT_W{1'b0}};
        uf_d      = 1'b1;
      end else begin
        pend_d[i] = nxt[CNT_W-1:0];
      end
    end
  end

  // State registers with synchronous reset overriding every event.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= {CNT_W{1'b0}};
      uf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
      uf_q <= uf_d;
    end
  end

  // busy shows the registered counters, forced low while reset is asserted.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) busy[i] = !reset && (pend_q[i] != {CNT_W{1'b0}});
  end

  assign underflow_err = uf_q;

endmodule
